// File: rtl/prng_ctrl.sv
// rtl/prng_ctrl.sv - round-robin controller sharing one prng_lcg between requesters
//
// Purpose: arbitrates draw/seed commands from REQ_N requesters, issues a
// single-cycle command to the PRNG, samples the PRNG output and returns it
// over a per-requester valid/ready response channel. Outside a transaction
// the PRNG is held in halt (prng_typ_sel = 0).
//
// Ports:
//   clk, rst_b             clock, asynchronous active-low reset
//   req_vld/req_cmd        per-requester request and command (0 draw, 1 seed)
//   req_dat                per-requester seed, slice i = [i*W +: W]
//   req_gnt                one-hot one-cycle acceptance pulse
//   rsp_vld/rsp_rdy        one-hot response valid, per-requester ready
//   rsp_dat                shared response data
//   prng_typ_sel           PRNG command: 0 halt, 1 step, 2 load seed
//   prng_t_sel/prng_t_dat  PRNG seed-load select and value
//   prng_r_dat             PRNG current output
//   draw_cnt               32-bit draw counter (only with PRNG_CTRL_DRAW_CNT_EN)
//
// Optional feature macro: PRNG_CTRL_DRAW_CNT_EN

module prng_ctrl #(
    parameter int REQ_N      = 2,
    parameter int PRNG_DAT_W = 25
) (
    input  logic                        clk,
    input  logic                        rst_b,
    input  logic [REQ_N-1:0]            req_vld,
    input  logic [REQ_N-1:0]            req_cmd,
    input  logic [REQ_N*PRNG_DAT_W-1:0] req_dat,
    output logic [REQ_N-1:0]            req_gnt,
    output logic [REQ_N-1:0]            rsp_vld,
    input  logic [REQ_N-1:0]            rsp_rdy,
    output logic [PRNG_DAT_W-1:0]       rsp_dat,
    output logic [1:0]                  prng_typ_sel,
    output logic                        prng_t_sel,
    output logic [PRNG_DAT_W-1:0]       prng_t_dat,
    input  logic [PRNG_DAT_W-1:0]       prng_r_dat
`ifdef PRNG_CTRL_DRAW_CNT_EN
    ,
    output logic [31:0]                 draw_cnt
`endif
);

    localparam int IDX_W = $clog2(REQ_N);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_EXEC   = 2'd1;
    localparam logic [1:0] S_SAMPLE = 2'd2;
    localparam logic [1:0] S_RESP   = 2'd3;

    localparam logic [1:0] TYP_HALT = 2'd0;
    localparam logic [1:0] TYP_STEP = 2'd1;
    localparam logic [1:0] TYP_LOAD = 2'd2;

    logic [1:0]            state_q, state_d;
    logic [IDX_W-1:0]      ptr_q, ptr_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [REQ_N-1:0]      gnt_q, gnt_d;
    logic [REQ_N-1:0]      rsp_vld_q, rsp_vld_d;
    logic [PRNG_DAT_W-1:0] rsp_dat_q, rsp_dat_d;
    logic [1:0]            typ_q, typ_d;
    logic                  tsel_q, tsel_d;
    logic [PRNG_DAT_W-1:0] tdat_q, tdat_d;

`ifdef PRNG_CTRL_DRAW_CNT_EN
    logic                  cmd_q, cmd_d;
    logic [31:0]           cnt_q, cnt_d;
`endif

    logic                  win_found;
    logic [IDX_W-1:0]      win_idx;
    logic [IDX_W-1:0]      cand;

    // Search upward from the pointer, wrapping, so the requester just served
    // is checked last on the next arbitration.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int k = 0; k < REQ_N; k++) begin
            cand = IDX_W'((int'(ptr_q) + k) % REQ_N);
            if (!win_found && req_vld[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        idx_d     = idx_q;
        gnt_d     = '0;
        rsp_vld_d = rsp_vld_q;
        rsp_dat_d = rsp_dat_q;
        typ_d     = TYP_HALT;
        tsel_d    = 1'b0;
        tdat_d    = '0;
`ifdef PRNG_CTRL_DRAW_CNT_EN
        cmd_d     = cmd_q;
        cnt_d     = cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (win_found) begin
                    idx_d          = win_idx;
                    gnt_d[win_idx] = 1'b1;
                    state_d        = S_EXEC;
`ifdef PRNG_CTRL_DRAW_CNT_EN
                    cmd_d          = req_cmd[win_idx];
`endif
                    if (req_cmd[win_idx]) begin
                        typ_d  = TYP_LOAD;
                        tsel_d = 1'b1;
                        tdat_d = req_dat[win_idx*PRNG_DAT_W +: PRNG_DAT_W];
                    end else begin
                        typ_d  = TYP_STEP;
                    end
                end
            end
            // Command outputs fall back to their defaults here, so the PRNG
            // sees exactly one command cycle.
            S_EXEC: begin
                state_d = S_SAMPLE;
            end
            S_SAMPLE: begin
                rsp_dat_d        = prng_r_dat;
                rsp_vld_d        = '0;
                rsp_vld_d[idx_q] = 1'b1;
                state_d          = S_RESP;
`ifdef PRNG_CTRL_DRAW_CNT_EN
                if (!cmd_q) begin
                    cnt_d = cnt_q + 32'd1;
                end
`endif
            end
            default: begin
                if (rsp_rdy[idx_q]) begin
                    rsp_vld_d = '0;
                    ptr_d     = (idx_q == IDX_W'(REQ_N - 1)) ? '0 : idx_q + 1'b1;
                    state_d   = S_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q   <= S_IDLE;
            ptr_q     <= '0;
            idx_q     <= '0;
            gnt_q     <= '0;
            rsp_vld_q <= '0;
            rsp_dat_q <= '0;
            typ_q     <= TYP_HALT;
            tsel_q    <= 1'b0;
            tdat_q    <= '0;
`ifdef PRNG_CTRL_DRAW_CNT_EN
            cmd_q     <= 1'b0;
            cnt_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            idx_q     <= idx_d;
            gnt_q     <= gnt_d;
            rsp_vld_q <= rsp_vld_d;
            rsp_dat_q <= rsp_dat_d;
            typ_q     <= typ_d;
            tsel_q    <= tsel_d;
            tdat_q    <= tdat_d;
`ifdef PRNG_CTRL_DRAW_CNT_EN
            cmd_q     <= cmd_d;
            cnt_q     <= cnt_d;
`endif
        end
    end

    assign req_gnt      = gnt_q;
    assign rsp_vld      = rsp_vld_q;
    assign rsp_dat      = rsp_dat_q;
    assign prng_typ_sel = typ_q;
    assign prng_t_sel   = tsel_q;
    assign prng_t_dat   = tdat_q;
`ifdef PRNG_CTRL_DRAW_CNT_EN
    assign draw_cnt     = cnt_q;
`endif

endmodule

// File: doc/prng_ctrl.md
# prng_ctrl

Round-robin controller that shares one `prng_lcg` instance between up to `REQ_N` requesters (key generation, error-vector sampling and similar units in the cryptoprocessor). It accepts draw or seed commands over a per-requester valid/grant interface and drives the PRNG's `prng_typ_sel`/`prng_t_sel`/`prng_t_dat` controls. It then returns the PRNG output over a valid/ready response channel. Outside a transaction the PRNG is always held in halt (`prng_typ_sel = 0`).

## Interface
Parameters:
- `REQ_N`, default 2: number of requesters, legal range 2..8.
- `PRNG_DAT_W`, default 25: PRNG data width; must match `prng_lcg`.

Ports:
- `clk`  in  1  single clock; all logic is rising-edge.
- `rst_b`  in  1  asynchronous active-low reset.
- `req_vld`  in  REQ_N  per-requester command request.
- `req_cmd`  in  REQ_N  per-requester command: 0 = draw, 1 = seed.
- `req_dat`  in  REQ_N*PRNG_DAT_W  per-requester seed value; slice i is bits `[i*W +: W]`.
- `req_gnt`  out  REQ_N  one-hot, one-cycle command acceptance pulse.
- `rsp_vld`  out  REQ_N  one-hot response valid to the granted requester.
- `rsp_rdy`  in  REQ_N  per-requester response ready.
- `rsp_dat`  out  PRNG_DAT_W  shared response data.
- `prng_typ_sel`  out  2  PRNG command: 0 = halt, 1 = step, 2 = load seed.
- `prng_t_sel`  out  1  PRNG seed-load select.
- `prng_t_dat`  out  PRNG_DAT_W  PRNG seed value.
- `prng_r_dat`  in  PRNG_DAT_W  PRNG current output.

## Operation
- Reset values:
  - `req_gnt`, `rsp_vld`, `rsp_dat`, `prng_typ_sel`, `prng_t_sel` and `prng_t_dat` are all 0.
  - State is IDLE and the round-robin pointer is 0.
- All outputs are registered.
- **IDLE**
  - If any `req_vld` is set, select the first set index searching upward from the pointer, wrapping at `REQ_N-1` to 0.
  - Latch the winner's index, `req_cmd` and `req_dat` slice.
  - Pulse `req_gnt[idx]` and go to EXEC.
  - Draw: `prng_typ_sel = 1`, `prng_t_sel = 0`.
  - Seed: `prng_typ_sel = 2`, `prng_t_sel = 1`, `prng_t_dat` = latched seed.
- **EXEC**: PRNG commands are present for exactly this one cycle. At the end of the cycle, return `prng_typ_sel`, `prng_t_sel` and `prng_t_dat` to 0 and go to SAMPLE.
- **SAMPLE**: capture `prng_r_dat` into `rsp_dat`, set `rsp_vld[idx]` and go to RESP.
  - For a seed command, `rsp_dat` equals the loaded seed (readback).
- **RESP**
  - Hold `rsp_vld[idx]` and `rsp_dat` stable until `rsp_rdy[idx]` is seen high at a clock edge.
  - On that edge: clear `rsp_vld`, set pointer = (idx+1) mod `REQ_N`, go to IDLE.
- Boundary and corner cases:
  - `rsp_rdy` of non-granted requesters is ignored.
  - `rsp_rdy` high before `rsp_vld` completes the handshake on the first RESP edge.
  - Requests arriving in EXEC, SAMPLE or RESP wait; `req_vld` is sampled only in IDLE.
  - A requester must hold `req_vld`, `req_cmd` and `req_dat` until `req_gnt`. Deasserting `req_vld` before grant withdraws the request with no side effect.
  - Simultaneous requests are resolved purely by pointer order, so no requester starves.
  - Reset mid-transaction aborts immediately: outputs return to reset values asynchronously, and the PRNG sees halt.

## Timing
- Request seen at edge E0:
  - `req_gnt` and the PRNG command are high in cycle E0–E1.
  - The PRNG updates at E1.
  - `rsp_vld` rises after E2.
  - With `rsp_rdy` already high, `rsp_vld` falls after E3.
- Minimum 4 cycles per transaction. The next grant is issued at the earliest on the edge after return to IDLE.
- `prng_typ_sel` is nonzero for exactly one cycle per transaction.

## Configuration
- `PRNG_CTRL_DRAW_CNT_EN`
  - Defined: adds output `draw_cnt` (32 bits, reset 0).
    - Increments by 1 at the SAMPLE edge of each draw command.
    - Seed commands do not change it.
    - Wraps from 2^32-1 to 0.
  - Undefined: the port and counter are absent; behaviour is otherwise identical.

## Test plan
- Reset with all `req_vld = 0` for 20 cycles, then release `rst_b`:
  - `prng_typ_sel` stays 0.
  - `req_gnt`, `rsp_vld` and `rsp_dat` stay 0.
- Requester 0 seeds 100:
  - `req_gnt = 01` one cycle.
  - `prng_typ_sel = 2`, `prng_t_sel = 1`, `prng_t_dat = 100` for one cycle.
  - `rsp_vld = 01` with `rsp_dat = 100`.
- After seed 100, requester 1 draws 3 times with `rsp_rdy` held high:
  - Each `rsp_dat` matches the `prng_lcg` golden model stepped 1, 2, 3 times from 100.
  - Each `prng_typ_sel = 1` pulse is exactly 1 cycle.
  - Successive grants are 4 cycles apart.
- Both requesters hold draw requests continuously: grants alternate 01, 10, 01, 10; no requester gets two grants in a row.
- Requester 0 draw with `rsp_rdy` low for 7 cycles: `rsp_vld` and `rsp_dat` stay stable, and no new grant is issued until the handshake completes.
- Assert `rst_b = 0` during EXEC of a draw: all outputs are 0 immediately; after release, a fresh seed of 100 reads back 100. With `PRNG_CTRL_DRAW_CNT_EN` defined, `draw_cnt` reads 0 after the reset.
